// File: rtl/attack_arbiter.sv
// attack_arbiter: per-player attack phase sequencing (startup/active/recovery) with hit and hitstun resolution.
// Define ATTACK_CLANK_EN to cancel simultaneous mutual hits as a clank instead of trading them.
module attack_arbiter #(
  parameter int STARTUP_FRAMES  = 4,
  parameter int ACTIVE_FRAMES   = 6,
  parameter int RECOVERY_FRAMES = 8,
  parameter int HITSTUN_FRAMES  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       p1_req,
  input  logic       p2_req,
  input  logic       p1_overlap,
  input  logic       p2_overlap,
  output logic [1:0] p1_phase,
  output logic [1:0] p2_phase,
  output logic       p1_stunned,
  output logic       p2_stunned,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       clank
);

  localparam logic [1:0] PH_IDLE     = 2'b00;
  localparam logic [1:0] PH_STARTUP  = 2'b01;
  localparam logic [1:0] PH_ACTIVE   = 2'b10;
  localparam logic [1:0] PH_RECOVERY = 2'b11;

  localparam logic [7:0] STARTUP_LD  = 8'(STARTUP_FRAMES);
  localparam logic [7:0] ACTIVE_LD   = 8'(ACTIVE_FRAMES);
  localparam logic [7:0] RECOVERY_LD = 8'(RECOVERY_FRAMES);
  localparam logic [7:0] HITSTUN_LD  = 8'(HITSTUN_FRAMES);

  typedef struct packed {
    logic [1:0] phase;
    logic [7:0] cnt;
    logic [7:0] stun;
    logic       landed;
  } player_t;

  localparam player_t PLAYER_RST = '{phase: PH_IDLE, cnt: 8'd0, stun: 8'd0, landed: 1'b0};

  player_t p1_r;
  player_t p2_r;
  player_t p1_nxt_s;
  player_t p2_nxt_s;
  logic    p1_cand_s;
  logic    p2_cand_s;
  logic    p1_hit_s;
  logic    p2_hit_s;
  logic    clank_s;
  logic    p1_hit_r;
  logic    p2_hit_r;
  logic    clank_r;
  logic    p1_stunned_r;
  logic    p2_stunned_r;

  // One frame of progression for a player; a phase counter of 1 means this tick ends the phase.
  function automatic player_t step_player(input player_t cur, input logic req,
                                          input logic self_cand, input logic opp_cand);
    player_t nxt;
    logic    clash;
    logic    struck;
    nxt = cur;
    if (cur.stun != 8'd0) begin
      nxt.stun = cur.stun - 8'd1;
    end else begin
      nxt.stun = 8'd0;
    end
    case (cur.phase)
      PH_IDLE: begin
        if (req && (cur.stun == 8'd0)) begin
          nxt.phase  = PH_STARTUP;
          nxt.cnt    = STARTUP_LD;
          nxt.landed = 1'b0;
        end else begin
          nxt.cnt = 8'd0;
        end
      end
      PH_STARTUP: begin
        if (cur.cnt <= 8'd1) begin
          nxt.phase = PH_ACTIVE;
          nxt.cnt   = ACTIVE_LD;
        end else begin
          nxt.cnt = cur.cnt - 8'd1;
        end
      end
      PH_ACTIVE: begin
        if (cur.cnt <= 8'd1) begin
          nxt.phase = PH_RECOVERY;
          nxt.cnt   = RECOVERY_LD;
        end else begin
          nxt.cnt = cur.cnt - 8'd1;
        end
      end
      PH_RECOVERY: begin
        if (cur.cnt <= 8'd1) begin
          nxt.phase = PH_IDLE;
          nxt.cnt   = 8'd0;
        end else begin
          nxt.cnt = cur.cnt - 8'd1;
        end
      end
      default: begin
        nxt.phase = PH_IDLE;
        nxt.cnt   = 8'd0;
      end
    endcase
    nxt.landed = nxt.landed | self_cand;
`ifdef ATTACK_CLANK_EN
    clash = self_cand & opp_cand;
`else
    clash = 1'b0;
`endif
    struck = opp_cand & ~clash;
    // Being struck overrides whatever this player's own transition or request would have done.
    case ({clash, struck})
      2'b10: begin
        nxt.phase = PH_RECOVERY;
        nxt.cnt   = RECOVERY_LD;
      end
      2'b01: begin
        nxt.phase = PH_IDLE;
        nxt.cnt   = 8'd0;
        nxt.stun  = HITSTUN_LD;
      end
      default: begin
      end
    endcase
    return nxt;
  endfunction

  // Hit candidacy, outcome pulses and next-frame state for both players.
  always_comb begin
    p1_cand_s = (p1_r.phase == PH_ACTIVE) && !p1_r.landed && p1_overlap;
    p2_cand_s = (p2_r.phase == PH_ACTIVE) && !p2_r.landed && p2_overlap;
    p1_nxt_s  = step_player(p1_r, p1_req, p1_cand_s, p2_cand_s);
    p2_nxt_s  = step_player(p2_r, p2_req, p2_cand_s, p1_cand_s);
`ifdef ATTACK_CLANK_EN
    clank_s   = p1_cand_s & p2_cand_s;
    p1_hit_s  = p1_cand_s & ~p2_cand_s;
    p2_hit_s  = p2_cand_s & ~p1_cand_s;
`else
    clank_s   = 1'b0;
    p1_hit_s  = p1_cand_s;
    p2_hit_s  = p2_cand_s;
`endif
  end

  // State advances only on frame ticks; pulses last exactly the clk after the deciding tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_r         <= PLAYER_RST;
      p2_r         <= PLAYER_RST;
      p1_hit_r     <= 1'b0;
      p2_hit_r     <= 1'b0;
      clank_r      <= 1'b0;
      p1_stunned_r <= 1'b0;
      p2_stunned_r <= 1'b0;
    end else if (frame_tick) begin
      p1_r         <= p1_nxt_s;
      p2_r         <= p2_nxt_s;
      p1_hit_r     <= p1_hit_s;
      p2_hit_r     <= p2_hit_s;
      clank_r      <= clank_s;
      p1_stunned_r <= (p1_nxt_s.stun != 8'd0);
      p2_stunned_r <= (p2_nxt_s.stun != 8'd0);
    end else begin
      p1_hit_r     <= 1'b0;
      p2_hit_r     <= 1'b0;
      clank_r      <= 1'b0;
    end
  end

  assign p1_phase   = p1_r.phase;
  assign p2_phase   = p2_r.phase;
  assign p1_stunned = p1_stunned_r;
  assign p2_stunned = p2_stunned_r;
  assign p1_hit     = p1_hit_r;
  assign p2_hit     = p2_hit_r;
  assign clank      = clank_r;

endmodule
